// File: rtl/mem_responder.sv
// Word-addressed data-memory target with a fixed access latency and one outstanding transaction.
// Latency: response valid LATENCY cycles after acceptance; req_ready held low until the response is taken.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem_q [DEPTH];

  logic          err_d;
  logic          commit_d;
  logic [AW-1:0] idx_d;
  logic [31:0]   rdata_d;

  // Word index beyond DEPTH is equivalent to a byte address >= 4*DEPTH.
  always_comb begin
    err_d    = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    idx_d    = addr_q[AW+1:2];
    commit_d = (state_q == S_WAIT) && (cnt_q == CW'(1));
    rdata_d  = (err_d || we_q) ? 32'h0 : mem_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= CW'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (commit_d) begin
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Array is never reset; a write is suppressed if reset lands on its commit edge.
  always_ff @(posedge clk) begin
    if (reset && commit_d && we_q && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized and directed requests against a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          ncnt = 0;
  logic [31:0] model [DEPTH];
  exp_t        exp_q[$];
  int          acc_q[$];
  int          acc_log[$];
  logic        prev_v = 1'b0;
  bit          rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: latency of each rising resp_valid, and scoreboard compare at each response handshake.
  always @(negedge clk) begin
    exp_t e;
    ncnt++;
    if (reset) begin
      if (req_valid && req_ready) begin
        acc_q.push_back(ncnt);
        acc_log.push_back(ncnt);
      end
      if (resp_valid && !prev_v) begin
        chk("accept_pending_on_rise", acc_q.size(), 1);
        if (acc_q.size() != 0) chk("latency", ncnt - acc_q.pop_front(), LAT + 1);
      end
      if (resp_valid && resp_ready) begin
        chk("expect_pending_on_resp", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
        end
      end
    end
    prev_v = resp_valid;
  end

  // Random response backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) resp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Drive a request and return just after its acceptance edge; track=0 leaves the model untouched.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit track);
    exp_t e;
    int   n;
    int   idx;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n >= 200, 0);
    if (track) begin
      if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) begin
        e.rdata = 32'h0; e.err = 1'b1;
      end else begin
        idx = int'(a / 4);
        e.err = 1'b0;
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
          e.rdata = 32'h0;
        end else begin
          e.rdata = model[idx];
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !resp_valid && req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 400, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] hd;
    logic        he;
    int          n;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    chk("reset_resp_err", resp_err, 0);

    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b1);
      wait_done();
    end

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1); wait_done();
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);        wait_done();

    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1); wait_done();
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1); wait_done();
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);        wait_done();
    do_req(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1); wait_done();
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 1'b1);        wait_done();

    do_req(1'b0, 32'h22, 32'h0, 4'h0, 1'b1);             wait_done();
    do_req(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 1'b1);     wait_done();
    do_req(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 1'b1); wait_done();
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);              wait_done();

    // Stall the response and confirm it is held stable.
    resp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rise_timeout", n >= 50, 0);
    hd = resp_rdata; he = resp_err;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, hd);
      chk("hold_err", resp_err, he);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", resp_valid, 0);
    chk("hold_release_req_ready", req_ready, 1);
    wait_done();

    // Reset during WAIT drops the write.
    do_req(1'b1, 32'h30, 32'h5A5A5A5A ^ model[12], 4'hF, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midreset_req_ready", req_ready, 1);
    chk("midreset_resp_valid", resp_valid, 0);
    chk("midreset_resp_rdata", resp_rdata, 0);
    reset = 1'b1;
    acc_q.delete();
    repeat (2 * LAT + 4) begin
      @(negedge clk);
      chk("midreset_no_valid", resp_valid, 0);
    end
    @(posedge clk); #1;
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b1); wait_done();

    // Streamed reads with req_valid held high.
    acc_log.delete();
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
    wait_done();
    chk("stream_accept_count", acc_log.size(), 4);
    for (int i = 1; i < 4 && i < acc_log.size(); i++)
      chk("stream_spacing", acc_log[i] - acc_log[i-1], LAT + 2);

    // Random mix with random backpressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       a = 32'(4 * DEPTH + 4 * $urandom_range(0, 7));
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_done();

    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b0, 32'(w * 4), 32'h0, 4'h0, 1'b1);
      wait_done();
    end

    chk("final_expect_queue_empty", exp_q.size(), 0);
    chk("final_accept_queue_empty", acc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
